// File: rtl/ctxt_event_sched.sv
// ctxt_event_sched
// Sits in front of the VITA context-packet generator on the TX error and
// flow-control path. TX events (sequence error, underflow, late time,
// burst ACK) and periodic flow-control (FC) updates are collected as pending
// bits. The highest-priority pending bit gets one trigger/message at a time.
// The next trigger is not issued until the generator returns sent and a
// programmable holdoff has elapsed.
//
// Ports
//   clk           system clock
//   reset         synchronous active-high full reset
//   clear         synchronous active-high soft clear (pending bits, counters)
//   ev_seq_err    1-cycle pulse, sequence error
//   ev_underflow  1-cycle pulse, TX underflow
//   ev_time_err   1-cycle pulse, late packet / time error
//   ev_burst_ack  1-cycle pulse, end of burst consumed
//   pkt_consumed  1-cycle pulse, one TX packet consumed
//   fc_cycles     cycles between periodic FC updates (0 disables)
//   fc_packets    consumed packets that force an FC update (0 disables)
//   trigger       1-cycle pulse to the generator
//   message       message code, stable from trigger until sent
//   seqnum        consumed-packet count snapshot, stable from trigger until sent
//   sent          1-cycle pulse from the generator, packet fully pushed
//   busy          high from trigger until the holdoff expires
module ctxt_event_sched #(
    parameter int unsigned HOLDOFF = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             ev_seq_err,
    input  logic             ev_underflow,
    input  logic             ev_time_err,
    input  logic             ev_burst_ack,
    input  logic             pkt_consumed,
    input  logic [CNT_W-1:0] fc_cycles,
    input  logic [15:0]      fc_packets,
    output logic             trigger,
    output logic [31:0]      message,
    output logic [31:0]      seqnum,
    input  logic             sent,
    output logic             busy
);

    localparam logic [31:0] MSG_ACK       = 32'h0000_0001;
    localparam logic [31:0] MSG_UNDERFLOW = 32'h0000_0002;
    localparam logic [31:0] MSG_SEQ_ERR   = 32'h0000_0004;
    localparam logic [31:0] MSG_TIME_ERR  = 32'h0000_0008;
    localparam logic [31:0] MSG_FC        = 32'h0000_0000;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    // HOLD always lasts at least one cycle, so HOLDOFF 0 and 1 behave alike.
    localparam logic [7:0] HOLD_LAST = (HOLDOFF == 32'd0) ? 8'd0 : 8'(HOLDOFF - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // pend / grant bit order: {fc, ack, time, under, seq}
    state_t           state_q, state_d;
    logic [4:0]       pend_q, pend_d;
    logic [4:0]       grant_q, grant_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [15:0]      pkt_since_q, pkt_since_d;
    logic [31:0]      pkt_total_q, pkt_total_d;
    logic [7:0]       hcnt_q, hcnt_d;
    logic             trigger_q, trigger_d;
    logic [31:0]      message_q, message_d;
    logic [31:0]      seqnum_q, seqnum_d;
    logic             busy_q, busy_d;

    logic             in_arb_s;
    logic [4:0]       grant_now_s;
    logic             timer_hit_s;
    logic             thresh_hit_s;
    logic [4:0]       set_s;
    logic             enter_arb_s;

    // Fixed priority: seq > under > time > ack > fc; returns a one-hot grant.
    function automatic logic [4:0] pick_highest(input logic [4:0] p);
        logic [4:0] g;
        if (p[0]) begin
            g = 5'b00001;
        end else if (p[1]) begin
            g = 5'b00010;
        end else if (p[2]) begin
            g = 5'b00100;
        end else if (p[3]) begin
            g = 5'b01000;
        end else if (p[4]) begin
            g = 5'b10000;
        end else begin
            g = 5'b00000;
        end
        return g;
    endfunction

    // Message code for a one-hot grant.
    function automatic logic [31:0] code_of(input logic [4:0] g);
        logic [31:0] c;
        case (g)
            5'b00001: c = MSG_SEQ_ERR;
            5'b00010: c = MSG_UNDERFLOW;
            5'b00100: c = MSG_TIME_ERR;
            5'b01000: c = MSG_ACK;
            default:  c = MSG_FC;
        endcase
        return c;
    endfunction

    // Pending bits and the FC / consumed-packet counters.
    always_comb begin
        // clear in ARB cancels the grant together with the trigger
        in_arb_s     = (state_q == ST_ARB) && !clear;
        grant_now_s  = in_arb_s ? grant_q : 5'b00000;
        timer_hit_s  = (fc_cycles != CNT_ZERO) && (cyc_cnt_q == (fc_cycles - CNT_ONE));
        // The packet threshold is a level on a counter that the FC grant is
        // zeroing, so it must not re-arm FC in that same cycle.
        thresh_hit_s = (fc_packets != 16'd0) && (pkt_since_q >= fc_packets) && !grant_now_s[4];
        set_s        = {timer_hit_s | thresh_hit_s, ev_burst_ack, ev_time_err,
                        ev_underflow, ev_seq_err};
        if (clear) begin
            pend_d      = 5'b00000;
            cyc_cnt_d   = CNT_ZERO;
            pkt_since_d = 16'd0;
            pkt_total_d = 32'd0;
        end else begin
            // set after grant-clear: an event in its own grant cycle survives
            pend_d = (pend_q & ~grant_now_s) | set_s;
            if (grant_now_s[4] || timer_hit_s) begin
                cyc_cnt_d = CNT_ZERO;
            end else begin
                cyc_cnt_d = cyc_cnt_q + CNT_ONE;
            end
            if (grant_now_s[4]) begin
                pkt_since_d = {15'd0, pkt_consumed};
            end else if (pkt_consumed && (pkt_since_q != 16'hFFFF)) begin
                pkt_since_d = pkt_since_q + 16'd1;
            end else begin
                pkt_since_d = pkt_since_q;
            end
            pkt_total_d = pkt_total_q + {31'd0, pkt_consumed};
        end
    end

    // Scheduler FSM next state and the registered output values.
    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        enter_arb_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else if (pend_q != 5'b00000) begin
                    state_d     = ST_ARB;
                    enter_arb_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sent) begin
                    state_d = ST_HOLD;
                    hcnt_d  = 8'd0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (hcnt_q >= HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // The ARB-cycle decision is registered on the edge into ARB: pend_d and
        // pkt_total_d are exactly the values that pend and pkt_total hold in ARB.
        grant_d   = enter_arb_s ? pick_highest(pend_d) : grant_q;
        message_d = enter_arb_s ? code_of(pick_highest(pend_d)) : message_q;
        seqnum_d  = enter_arb_s ? pkt_total_d : seqnum_q;
        trigger_d = enter_arb_s;
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pend_q      <= 5'b00000;
            grant_q     <= 5'b00000;
            cyc_cnt_q   <= CNT_ZERO;
            pkt_since_q <= 16'd0;
            pkt_total_q <= 32'd0;
            hcnt_q      <= 8'd0;
            trigger_q   <= 1'b0;
            message_q   <= 32'd0;
            seqnum_q    <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            grant_q     <= grant_d;
            cyc_cnt_q   <= cyc_cnt_d;
            pkt_since_q <= pkt_since_d;
            pkt_total_q <= pkt_total_d;
            hcnt_q      <= hcnt_d;
            trigger_q   <= trigger_d;
            message_q   <= message_d;
            seqnum_q    <= seqnum_d;
            busy_q      <= busy_d;
        end
    end

    // clear arriving in ARB suppresses the pulse that cycle.
    assign trigger = trigger_q & ~clear;
    assign message = message_q;
    assign seqnum  = seqnum_q;
    assign busy    = busy_q;

endmodule
